// File: rtl/di_bus_arbiter.sv
// Round-robin arbiter for the shared 32-bit memory data-in path
// (CPU, DMA, protocol unit) with fixed-length accesses and locked bursts.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high
//   req     [0] CPU, [1] DMA, [2] protocol; held until ack
//   lock    per-requester request to keep the bus for another access
//   gnt     one-hot grant to current owner, 000 when idle
//   sel_DI  data-in mux select: 00 CPU, 01 DMA, 10 protocol, 11 none
//   mem_we  memory write strobe, one cycle per access
//   ack     one-cycle completion pulse to the owner
//   busy    high whenever the arbiter is not idle
module di_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_LOCK    = 16,
    parameter int CW          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    output logic [2:0] gnt,
    output logic [1:0] sel_DI,
    output logic       mem_we,
    output logic [2:0] ack,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);
    localparam logic [1:0]    SEL_NONE  = 2'b11;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] lock_q, lock_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    own_d;
    logic [2:0]    gnt_d;
    logic [1:0]    sel_d;
    logic          we_d;
    logic [2:0]    ack_d;
    logic          busy_d;

    // Round-robin pick: search from (last+1) mod 3 upward. The loop runs
    // backwards so the earliest requester in search order is assigned last.
    function automatic logic [1:0] rr_pick(input logic [2:0] r,
                                           input logic [1:0] last);
        logic [1:0] pick;
        pick = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            int k;
            k = (int'(last) + 1 + i) % 3;
            if (r[k]) pick = 2'(k);
        end
        return pick;
    endfunction

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        lock_d  = lock_q;
        last_d  = last_q;
        own_d   = sel_DI;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ACCESS;
                    own_d   = rr_pick(req, last_q);
                    wait_d  = '0;
                end
            end
            ACCESS: begin
                wait_d = wait_q + CW'(1);
                if (wait_q == WAIT_LAST) state_d = DONE;
            end
            DONE: begin
                // gnt is one-hot on the owner, so this tests lock/req of the owner
                if (|(lock & req & gnt) && lock_q < LOCK_LAST) begin
                    state_d = ACCESS;
                    lock_d  = lock_q + CW'(1);
                    wait_d  = '0;
                end else begin
                    state_d = IDLE;
                    last_d  = sel_DI;
                    lock_d  = '0;
                    wait_d  = '0;
                    own_d   = SEL_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
                lock_d  = '0;
                own_d   = SEL_NONE;
            end
        endcase

        // Outputs are derived from the next state so they can be registered
        // and still line up with the state they describe.
        busy_d = (state_d != IDLE);
        gnt_d  = busy_d ? (3'b001 << own_d) : 3'b000;
        sel_d  = busy_d ? own_d : SEL_NONE;
        we_d   = (state_d == ACCESS) && (wait_d == WAIT_LAST);
        ack_d  = (state_d == DONE) ? gnt_d : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            lock_q  <= '0;
            last_q  <= 2'd2;
            gnt     <= 3'b000;
            sel_DI  <= SEL_NONE;
            mem_we  <= 1'b0;
            ack     <= 3'b000;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            gnt     <= gnt_d;
            sel_DI  <= sel_d;
            mem_we  <= we_d;
            ack     <= ack_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_di_bus_arbiter.sv
// Self-checking bench for di_bus_arbiter: vector table, directed
// multi-cycle sequences and randomized traffic against a tenure model.
module tb_di_bus_arbiter;

    localparam int W  = 2;
    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] gnt;
    logic [1:0] sel_DI;
    logic       mem_we;
    logic [2:0] ack;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    di_bus_arbiter #(
        .WAIT_CYCLES(W),
        .MAX_LOCK   (ML),
        .CW         (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .gnt   (gnt),
        .sel_DI(sel_DI),
        .mem_we(mem_we),
        .ack   (ack),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Tenure model: owner (-1 = idle), pos = cycle within the current
    // access (1..W are the access cycles, W+1 is the ack cycle),
    // acc = number of accesses in the current burst.
    int m_owner = -1;
    int m_pos   = 0;
    int m_acc   = 0;
    int m_last  = 2;

    function automatic void model_step(input logic r, input logic [2:0] rq,
                                       input logic [2:0] lk);
        if (r) begin
            m_owner = -1; m_pos = 0; m_acc = 0; m_last = 2;
        end else if (m_owner < 0) begin
            for (int i = 0; i < 3; i++) begin
                int k;
                k = (m_last + 1 + i) % 3;
                if (m_owner < 0 && rq[k]) m_owner = k;
            end
            if (m_owner >= 0) begin
                m_pos = 1; m_acc = 1;
            end
        end else if (m_pos <= W) begin
            m_pos++;
        end else if (lk[m_owner] && rq[m_owner] && m_acc < ML) begin
            m_acc++; m_pos = 1;
        end else begin
            m_last = m_owner; m_owner = -1; m_pos = 0; m_acc = 0;
        end
    endfunction

    function automatic logic [9:0] model_out();
        logic [2:0] g;
        logic [1:0] s;
        logic       we;
        logic [2:0] a;
        g  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
        s  = (m_owner >= 0) ? 2'(m_owner) : 2'b11;
        we = (m_owner >= 0) && (m_pos == W);
        a  = (m_owner >= 0 && m_pos == W + 1) ? g : 3'b000;
        return {g, s, we, a, (m_owner >= 0)};
    endfunction

    function automatic logic [9:0] dut_out();
        return {gnt, sel_DI, mem_we, ack, busy};
    endfunction

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got gnt/sel/we/ack/busy=%b required %b",
                     name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, then compare
    // everything on the falling edge.
    task automatic cyc(input logic r, input logic [2:0] rq,
                       input logic [2:0] lk);
        reset = r; req = rq; lock = lk;
        @(posedge clk);
        model_step(r, rq, lk);
        @(negedge clk);
        chk("model", dut_out(), model_out());
    endtask

    function automatic logic [9:0] pk(input logic [2:0] g, input logic [1:0] s,
                                      input logic we, input logic [2:0] a,
                                      input logic b);
        return {g, s, we, a, b};
    endfunction

    typedef struct {
        logic       rst;
        logic [2:0] rq;
        logic [2:0] lk;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[$];
    localparam logic [9:0] IDLE_V = 10'b000_11_0_000_0;

    initial begin
        reset = 1'b1; req = 3'b000; lock = 3'b000;

        // single CPU access, then req=111 rotation after a fresh reset
        tbl.push_back('{1'b1, 3'b000, 3'b000, IDLE_V});
        tbl.push_back('{1'b0, 3'b001, 3'b000, pk(3'b001, 2'b00, 0, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b001, 3'b000, pk(3'b001, 2'b00, 1, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b001, 3'b000, pk(3'b001, 2'b00, 0, 3'b001, 1)});
        tbl.push_back('{1'b0, 3'b000, 3'b000, IDLE_V});
        tbl.push_back('{1'b1, 3'b000, 3'b000, IDLE_V});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b001, 2'b00, 0, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b001, 2'b00, 1, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b001, 2'b00, 0, 3'b001, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, IDLE_V});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b010, 2'b01, 0, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b010, 2'b01, 1, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b010, 2'b01, 0, 3'b010, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, IDLE_V});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b100, 2'b10, 0, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b100, 2'b10, 1, 3'b000, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b100, 2'b10, 0, 3'b100, 1)});
        tbl.push_back('{1'b0, 3'b111, 3'b000, IDLE_V});
        tbl.push_back('{1'b0, 3'b111, 3'b000, pk(3'b001, 2'b00, 0, 3'b000, 1)});

        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].rq, tbl[i].lk);
            chk($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // idle with no requests
        cyc(1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 3'b000, 3'b000);
            chk("idle_quiet", dut_out(), IDLE_V);
        end

        // locked DMA burst after a CPU tenure
        cyc(1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'b011, 3'b010);
        cyc(1'b0, 3'b011, 3'b010);
        chk("burst_cpu_gap", dut_out(), IDLE_V);
        for (int k = 0; k < ML; k++) begin
            for (int j = 0; j < 3; j++) begin
                cyc(1'b0, 3'b011, 3'b010);
                chk($sformatf("burst_dma_%0d_%0d", k, j), dut_out(),
                    pk(3'b010, 2'b01, (j == 1), (j == 2) ? 3'b010 : 3'b000, 1));
            end
        end
        cyc(1'b0, 3'b011, 3'b010);
        chk("burst_end_idle", dut_out(), IDLE_V);
        cyc(1'b0, 3'b011, 3'b010);
        chk("burst_then_cpu", dut_out(), pk(3'b001, 2'b00, 0, 3'b000, 1));

        // reset in the first cycle of a DMA access
        cyc(1'b1, 3'b000, 3'b000);
        cyc(1'b0, 3'b010, 3'b000);
        chk("rst_dma_gnt", dut_out(), pk(3'b010, 2'b01, 0, 3'b000, 1));
        cyc(1'b1, 3'b010, 3'b000);
        chk("rst_abort", dut_out(), IDLE_V);
        cyc(1'b0, 3'b000, 3'b000);
        chk("rst_no_ack", dut_out(), IDLE_V);
        cyc(1'b0, 3'b111, 3'b000);
        chk("rst_cpu_first", dut_out(), pk(3'b001, 2'b00, 0, 3'b000, 1));

        // protocol request dropped mid-access with lock held
        cyc(1'b1, 3'b000, 3'b000);
        cyc(1'b0, 3'b100, 3'b100);
        chk("drop_gnt", dut_out(), pk(3'b100, 2'b10, 0, 3'b000, 1));
        cyc(1'b0, 3'b000, 3'b100);
        chk("drop_we", dut_out(), pk(3'b100, 2'b10, 1, 3'b000, 1));
        cyc(1'b0, 3'b000, 3'b100);
        chk("drop_ack", dut_out(), pk(3'b100, 2'b10, 0, 3'b100, 1));
        cyc(1'b0, 3'b000, 3'b100);
        chk("drop_idle", dut_out(), IDLE_V);

        // randomized traffic against the model
        cyc(1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [2:0] rq;
            logic [2:0] lk;
            r  = ($urandom_range(0, 99) == 0);
            rq = 3'($urandom);
            lk = 3'($urandom) | 3'($urandom);
            cyc(r, rq, lk);
            if (sel_DI == 2'b11 && gnt != 3'b000) begin
                checks++;
                failures++;
                $display("FAIL sel_gnt_excl: got sel_DI=%b gnt=%b required no grant",
                         sel_DI, gnt);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
